// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization network endpoints:
// core-initiator FSM states and the error codes returned to the core.
package fractal_sync_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } init_state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_LEVEL   = 3'd1,
        ERR_REMOTE  = 3'd2,
        ERR_TIMEOUT = 3'd3
    } init_err_e;

endpackage

// File: rtl/fractal_sync_timeout_cnt.sv
// Saturating cycle counter that guards the wait for a wake response.
// expired_o rises on the LIMIT-th enabled cycle after a clear.
module fractal_sync_timeout_cnt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_WIDTH = $clog2(LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LIMIT - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = en_i && (r_cnt == LAST);

endmodule

// File: rtl/fractal_sync_core_initiator.sv
// Core-side barrier initiator: takes one (level, id) request, sends it up the
// node tree, waits for the matching wake and reports completion or an error.
module fractal_sync_core_initiator
    import fractal_sync_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH    = 1,
    parameter int unsigned ID_WIDTH       = 1,
    parameter int unsigned MAX_LEVEL      = 2**LEVEL_WIDTH - 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LEVEL_WIDTH-1:0] req_level_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic                   up_valid_o,
    input  logic                   up_ready_i,
    output logic [LEVEL_WIDTH-1:0] up_level_o,
    output logic [ID_WIDTH-1:0]    up_id_o,
    input  logic                   wake_valid_i,
    input  logic [LEVEL_WIDTH-1:0] wake_level_i,
    input  logic [ID_WIDTH-1:0]    wake_id_i,
    input  logic                   wake_err_i,
    output logic                   done_o,
    output logic                   err_o,
    output logic [2:0]             err_code_o,
    output logic                   busy_o
);

    // One extra bit keeps the range check meaningful when MAX_LEVEL is the field maximum.
    localparam logic [LEVEL_WIDTH:0] MAX_LEVEL_EXT = (LEVEL_WIDTH + 1)'(MAX_LEVEL);

    init_state_e             r_state, w_state_next;
    init_err_e               r_code, w_code_next;
    logic [LEVEL_WIDTH-1:0]  r_level;
    logic [ID_WIDTH-1:0]     r_id;
    logic                    stray_seen_q;

    logic w_latch;
    logic w_level_bad;
    logic w_up_hs;
    logic w_wake_match;
    logic w_expired;

    assign w_level_bad  = {1'b0, req_level_i} > MAX_LEVEL_EXT;
    assign w_up_hs      = (r_state == SEND) && up_ready_i;
    assign w_wake_match = wake_valid_i && (r_state == WAIT) &&
                          (wake_level_i == r_level) && (wake_id_i == r_id);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            fractal_sync_timeout_cnt #(
                .LIMIT (TIMEOUT_CYCLES)
            ) u_timeout_cnt (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clear_i   (w_up_hs),
                .en_i      (r_state == WAIT),
                .expired_o (w_expired)
            );
        end else begin : g_no_timeout
            assign w_expired = 1'b0;
        end
    endgenerate

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_latch = 1'b1;
                    if (w_level_bad) begin
                        w_state_next = RESP;
                        w_code_next  = ERR_LEVEL;
                    end else begin
                        w_state_next = SEND;
                    end
                end
            end
            SEND: begin
                if (up_ready_i) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // A matching wake takes priority over a simultaneous timeout.
                if (w_wake_match) begin
                    w_state_next = RESP;
                    w_code_next  = wake_err_i ? ERR_REMOTE : ERR_NONE;
                end else if (w_expired) begin
                    w_state_next = RESP;
                    w_code_next  = ERR_TIMEOUT;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_code       <= ERR_NONE;
            r_level      <= '0;
            r_id         <= '0;
            stray_seen_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            if (w_latch) begin
                r_level <= req_level_i;
                r_id    <= req_id_i;
            end
            if (wake_valid_i && !w_wake_match) begin
                stray_seen_q <= 1'b1;
            end
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign up_valid_o  = (r_state == SEND);
    assign up_level_o  = r_level;
    assign up_id_o     = r_id;
    assign done_o      = (r_state == RESP);
    assign err_o       = done_o && (r_code != ERR_NONE);
    assign err_code_o  = done_o ? r_code : ERR_NONE;
    assign busy_o      = (r_state != IDLE);

    a_up_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (up_valid_o && !up_ready_i) |=> (up_valid_o && $stable(up_level_o) && $stable(up_id_o)));

    a_stray_cause: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $rose(stray_seen_q) |-> $past(wake_valid_i));

endmodule

// File: tb/tb_fractal_sync_core_initiator.sv
// Self-checking bench for fractal_sync_core_initiator: directed scenarios plus
// randomized transactions checked against an outcome model of the barrier protocol.
module tb_fractal_sync_core_initiator;

    localparam int LW   = 2;
    localparam int IW   = 3;
    localparam int MAXL = 2;
    localparam int T    = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [LW-1:0] req_level_i = '0;
    logic [IW-1:0] req_id_i = '0;
    logic          up_valid_o;
    logic          up_ready_i = 1'b0;
    logic [LW-1:0] up_level_o;
    logic [IW-1:0] up_id_o;
    logic          wake_valid_i = 1'b0;
    logic [LW-1:0] wake_level_i = '0;
    logic [IW-1:0] wake_id_i = '0;
    logic          wake_err_i = 1'b0;
    logic          done_o;
    logic          err_o;
    logic [2:0]    err_code_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fractal_sync_core_initiator #(
        .LEVEL_WIDTH    (LW),
        .ID_WIDTH       (IW),
        .MAX_LEVEL      (MAXL),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_level_i  (req_level_i),
        .req_id_i     (req_id_i),
        .up_valid_o   (up_valid_o),
        .up_ready_i   (up_ready_i),
        .up_level_o   (up_level_o),
        .up_id_o      (up_id_o),
        .wake_valid_i (wake_valid_i),
        .wake_level_i (wake_level_i),
        .wake_id_i    (wake_id_i),
        .wake_err_i   (wake_err_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_code_o   (err_code_o),
        .busy_o       (busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Outcome model: WAIT cycles from entering WAIT until done, and the reported code.
    function automatic int exp_cycles(input int wake_delay);
        return (wake_delay >= 0 && wake_delay < T) ? wake_delay + 1 : T;
    endfunction

    function automatic logic [2:0] exp_code(input int lvl, input int wake_delay, input bit werr);
        if (lvl > MAXL) return 3'd1;
        if (wake_delay >= 0 && wake_delay < T) return werr ? 3'd2 : 3'd0;
        return 3'd3;
    endfunction

    // wake_delay < 0 means no wake; stray_at is the WAIT cycle of a wrong-id wake;
    // send_wake puts a matching wake on the first SEND cycle (must be ignored).
    task automatic run_txn(input string name, input int lvl, input int id, input int stall,
                           input int wake_delay, input bit werr, input int stray_at,
                           input bit send_wake);
        logic [2:0]    ec;
        logic [LW-1:0] l;
        logic [IW-1:0] d;
        int            cycles;
        ec = exp_code(lvl, wake_delay, werr);
        l  = lvl[LW-1:0];
        d  = id[IW-1:0];
        req_valid_i = 1'b1;
        req_level_i = l;
        req_id_i    = d;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b want 1", name, req_ready_o);
        end
        tick();
        req_valid_i = 1'b0;
        if (lvl > MAXL) begin
            checks++;
            if ({done_o, err_o, err_code_o, up_valid_o} !== {1'b1, 1'b1, ec, 1'b0}) begin
                errors++;
                $display("FAIL %s level_err: got done=%b err=%b code=%0d upv=%b want 1 1 %0d 0",
                         name, done_o, err_o, err_code_o, up_valid_o, ec);
            end
        end else begin
            for (int s = 0; s <= stall; s++) begin
                up_ready_i   = (s == stall);
                wake_valid_i = send_wake && (s == 0);
                wake_level_i = l;
                wake_id_i    = d;
                wake_err_i   = 1'b0;
                checks++;
                if ({up_valid_o, req_ready_o, busy_o, up_level_o, up_id_o} !==
                    {1'b1, 1'b0, 1'b1, l, d}) begin
                    errors++;
                    $display("FAIL %s send[%0d]: got upv=%b rdy=%b busy=%b lvl=%0d id=%0d want 1 0 1 %0d %0d",
                             name, s, up_valid_o, req_ready_o, busy_o, up_level_o, up_id_o, l, d);
                end
                tick();
            end
            up_ready_i   = 1'b0;
            wake_valid_i = 1'b0;
            cycles = 0;
            while (!done_o && cycles < T + 4) begin
                wake_valid_i = (cycles == wake_delay) || (cycles == stray_at);
                wake_level_i = l;
                wake_id_i    = (cycles == stray_at) ? (d ^ 3'd1) : d;
                wake_err_i   = werr;
                checks++;
                if ({busy_o, req_ready_o, up_valid_o} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s wait[%0d]: got busy=%b rdy=%b upv=%b want 1 0 0",
                             name, cycles, busy_o, req_ready_o, up_valid_o);
                end
                tick();
                cycles++;
            end
            wake_valid_i = 1'b0;
            wake_err_i   = 1'b0;
            checks++;
            if (cycles != exp_cycles(wake_delay)) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles want %0d", name, cycles, exp_cycles(wake_delay));
            end
            checks++;
            if ({done_o, err_o, err_code_o} !== {1'b1, ec != 3'd0, ec}) begin
                errors++;
                $display("FAIL %s result: got done=%b err=%b code=%0d want 1 %b %0d",
                         name, done_o, err_o, err_code_o, ec != 3'd0, ec);
            end
        end
        tick();
        checks++;
        if ({done_o, busy_o, req_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL %s after: got done=%b busy=%b rdy=%b want 0 0 1", name, done_o, busy_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready_o, up_valid_o, done_o, err_o, err_code_o, busy_o, up_level_o, up_id_o} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset: got rdy=%b upv=%b done=%b err=%b code=%0d busy=%b lvl=%0d id=%0d want 1 0 0 0 0 0 0 0",
                     req_ready_o, up_valid_o, done_o, err_o, err_code_o, busy_o, up_level_o, up_id_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_txn("basic_latency", 1, 5, 0, 0, 1'b0, -1, 1'b0);
        run_txn("basic_delay2", 1, 5, 0, 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 2, 6, 4, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_level_error();
        run_txn("level_error", 3, 2, 0, -1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 0, 7, 0, -1, 1'b0, -1, 1'b0);
        run_txn("timeout_tie", 0, 7, 0, T - 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_stray_remote();
        wake_valid_i = 1'b1;
        wake_level_i = 2'd1;
        wake_id_i    = 3'd5;
        tick();
        wake_valid_i = 1'b0;
        checks++;
        if ({busy_o, done_o, req_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL idle_wake: got busy=%b done=%b rdy=%b want 0 0 1", busy_o, done_o, req_ready_o);
        end
        run_txn("stray_remote", 1, 5, 0, 3, 1'b1, 1, 1'b0);
        run_txn("wake_in_send", 1, 5, 2, 2, 1'b0, -1, 1'b1);
        run_txn("wake_on_hs", 1, 5, 0, -1, 1'b0, -1, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        req_valid_i = 1'b1;
        req_level_i = 2'd2;
        req_id_i    = 3'd3;
        tick();
        req_valid_i = 1'b0;
        up_ready_i  = 1'b1;
        tick();
        up_ready_i  = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_busy: got %b want 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, up_valid_o, done_o, err_o, err_code_o, busy_o, up_level_o, up_id_o} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b upv=%b done=%b err=%b code=%0d busy=%b lvl=%0d id=%0d want 1 0 0 0 0 0 0 0",
                     req_ready_o, up_valid_o, done_o, err_o, err_code_o, busy_o, up_level_o, up_id_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        run_txn("after_reset", 2, 3, 1, 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int lvl, id, stall, wd, sa;
            bit werr;
            lvl   = int'($urandom_range(0, 3));
            id    = int'($urandom_range(0, 7));
            stall = int'($urandom_range(0, 3));
            wd    = int'($urandom_range(0, 10)) - 1;
            werr  = 1'($urandom_range(0, 1));
            sa    = int'($urandom_range(0, T)) - 1;
            if (sa == wd) sa = -1;
            run_txn($sformatf("random%0d", n), lvl, id, stall, wd, werr, sa, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_level_error();
        test_timeout();
        test_stray_remote();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
